// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: the sequencing state
// enum and the width helper for the shared stage/timeout timer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MEM_REL  = 3'd1,
        MEM_INIT = 3'd2,
        GAME_REL = 3'd3,
        PIX_REL  = 3'd4,
        RUN      = 3'd5,
        FAULT    = 3'd6
    } rst_state_t;

    // One timer serves both the stage delays and the init timeout, so it must
    // hold the larger of the two counts.
    function automatic int timer_width(input int stage_delay, input int init_timeout);
        int longest;
        longest = (stage_delay > init_timeout) ? stage_delay : init_timeout;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/rst_stage_timer.sv
// Loadable down-counter used by the reset sequencer. The owner pulses restart
// on every state entry with the number of cycles-minus-one the new state must
// wait; done is high once the count has run down to zero.
module rst_stage_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         restart,
    input  logic [W-1:0] start_value,
    output logic         done
);

    logic [W-1:0] count_reg;

    // Reload on state entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (restart) begin
            count_reg <= start_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Ordered per-domain reset release driven by the clock-manager lock
// indicators: memory first, then game logic (gated on memory init), then
// video. Any lock loss re-asserts every reset at once; an init timeout parks
// in FAULT for one stage delay and then retries from IDLE.
// Optional feature: define RST_SEQ_LOSS_CNT_EN to add the saturating
// loss_count output and its counter.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int STAGE_DELAY  = 16,
    parameter int INIT_TIMEOUT = 65535,
    parameter int CNT_W        = 8
) (
    input  logic             clk_50mhz,
    input  logic             reset,
    input  logic             pixel_locked,
    input  logic             game_locked,
    input  logic             mem_locked,
    input  logic             mem_init_done,
    output logic             mem_rst,
    output logic             game_rst,
    output logic             pixel_rst,
    output logic             sys_ready,
    output logic             init_fault
`ifdef RST_SEQ_LOSS_CNT_EN
    ,
    output logic [CNT_W-1:0] loss_count
`endif
);

    localparam int TIMER_W = timer_width(STAGE_DELAY, INIT_TIMEOUT);

    // Timer is loaded with (cycles - 1) so done rises on the Nth edge after entry.
    localparam logic [TIMER_W-1:0] STAGE_LOAD = TIMER_W'(STAGE_DELAY - 1);
    localparam logic [TIMER_W-1:0] INIT_LOAD  = TIMER_W'(INIT_TIMEOUT - 1);

    rst_state_t         state_reg;
    rst_state_t         state_next;
    logic               all_locked;
    logic               lock_loss;
    logic               timer_done;
    logic               timer_restart;
    logic [TIMER_W-1:0] timer_start;

    logic mem_rst_reg;
    logic game_rst_reg;
    logic pixel_rst_reg;
    logic sys_ready_reg;
    logic init_fault_reg;

    assign all_locked = pixel_locked & game_locked & mem_locked;

    // Lock loss only counts while a release is in progress or complete; IDLE is
    // already fully in reset and FAULT always runs to completion.
    always_comb begin
        lock_loss = 1'b0;
        if (!all_locked) begin
            lock_loss = (state_reg inside {MEM_REL, MEM_INIT, GAME_REL, PIX_REL, RUN});
        end
    end

    // Next-state selection; lock loss overrides timeout, which overrides
    // mem_init_done, which overrides stage expiry.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (all_locked) state_next = MEM_REL;
            MEM_REL:  if (timer_done) state_next = MEM_INIT;
            MEM_INIT: begin
                if (timer_done) begin
                    state_next = FAULT;
                end else if (mem_init_done) begin
                    state_next = GAME_REL;
                end
            end
            GAME_REL: if (timer_done) state_next = PIX_REL;
            PIX_REL:  if (timer_done) state_next = RUN;
            RUN:      state_next = RUN;
            FAULT:    if (timer_done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (lock_loss) begin
            state_next = IDLE;
        end
    end

    // Restart the shared timer on every state entry with the new state's wait.
    always_comb begin
        timer_restart = (state_next != state_reg);
        timer_start   = '0;
        case (state_next)
            MEM_INIT:                        timer_start = INIT_LOAD;
            MEM_REL, GAME_REL, PIX_REL, FAULT: timer_start = STAGE_LOAD;
            default:                         timer_start = '0;
        endcase
    end

    rst_stage_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk        (clk_50mhz),
        .srst       (reset),
        .restart    (timer_restart),
        .start_value(timer_start),
        .done       (timer_done)
    );

    // State register plus outputs registered from the state being entered, so
    // every reset moves on the same edge as the transition that causes it.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state_reg      <= IDLE;
            mem_rst_reg    <= 1'b1;
            game_rst_reg   <= 1'b1;
            pixel_rst_reg  <= 1'b1;
            sys_ready_reg  <= 1'b0;
            init_fault_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mem_rst_reg   <= !(state_next inside {MEM_INIT, GAME_REL, PIX_REL, RUN});
            game_rst_reg  <= !(state_next inside {PIX_REL, RUN});
            pixel_rst_reg <= (state_next != RUN);
            sys_ready_reg <= (state_next == RUN);
            if (state_next == FAULT) begin
                init_fault_reg <= 1'b1;
            end else if (state_next == RUN) begin
                init_fault_reg <= 1'b0;
            end
        end
    end

    assign mem_rst    = mem_rst_reg;
    assign game_rst   = game_rst_reg;
    assign pixel_rst  = pixel_rst_reg;
    assign sys_ready  = sys_ready_reg;
    assign init_fault = init_fault_reg;

`ifdef RST_SEQ_LOSS_CNT_EN
    logic [CNT_W-1:0] loss_count_reg;

    // Saturating lock-loss count; only reset clears it.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            loss_count_reg <= '0;
        end else if (lock_loss && (loss_count_reg != {CNT_W{1'b1}})) begin
            loss_count_reg <= loss_count_reg + 1'b1;
        end
    end

    assign loss_count = loss_count_reg;
`else
    // Loss counting is compiled out; CNT_W only describes the absent port.
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end
`endif

endmodule
